// File: rtl/ram_scan_pkg.sv
// Shared defaults and FSM state type for the RAM scan reader.
package ram_scan_pkg;

  localparam int unsigned DefaultAddrW = 5;
  localparam int unsigned DefaultDataW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StShow
  } scan_state_e;

endpackage

// File: rtl/ram_scan_reader_if.sv
// RAM read port, RAM write-port snoop and display outputs of the scan reader.
interface ram_scan_reader_if
  import ram_scan_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en_snoop;
  logic [ADDR_W-1:0] wr_addr_snoop;
  logic [DATA_W-1:0] wr_data_snoop;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  modport master (
    output rd_en, rd_addr, disp_addr, disp_data, disp_valid,
    input  rd_data, wr_en_snoop, wr_addr_snoop, wr_data_snoop
  );

  modport slave (
    input  rd_en, rd_addr, disp_addr, disp_data, disp_valid,
    output rd_data, wr_en_snoop, wr_addr_snoop, wr_data_snoop
  );

endinterface

// File: rtl/tick_divider.sv
// Step timer: counts enabled cycles and pulses tick on the TICK_DIV-th one.
module tick_divider #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == CntLast) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_scan_reader.sv
// Steps through RAM one word per tick, shows the word, and keeps it coherent
// with writes observed on the RAM write port.
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  ram_scan_reader_if.master  bus
);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              bypass_q, bypass_d;
  logic [DATA_W-1:0] bypass_data_q, bypass_data_d;
  logic              tick;
  logic              snoop_hit;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clock (clock),
    .reset (reset),
    .clear (state_q == StWait),
    .run   ((state_q == StShow) && enable),
    .tick  (tick)
  );

  assign snoop_hit = bus.wr_en_snoop && (bus.wr_addr_snoop == disp_addr_q);

  always_comb begin
    state_d       = state_q;
    disp_addr_d   = disp_addr_q;
    disp_data_d   = disp_data_q;
    disp_valid_d  = disp_valid_q;
    bypass_d      = bypass_q;
    bypass_data_d = bypass_data_q;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StIssue;
      end
      StIssue: begin
        state_d = StWait;
        if (snoop_hit) begin
          bypass_d      = 1'b1;
          bypass_data_d = bus.wr_data_snoop;
        end
      end
      StWait: begin
        // A write in this very cycle is newer than anything captured earlier.
        state_d      = StShow;
        disp_valid_d = 1'b1;
        bypass_d     = 1'b0;
        if (snoop_hit) begin
          disp_data_d = bus.wr_data_snoop;
        end else if (bypass_q) begin
          disp_data_d = bypass_data_q;
        end else begin
          disp_data_d = bus.rd_data;
        end
      end
      StShow: begin
        if (snoop_hit) disp_data_d = bus.wr_data_snoop;
        if (tick) begin
          state_d     = StIssue;
          disp_addr_d = disp_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      disp_addr_q   <= '0;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      bypass_q      <= 1'b0;
      bypass_data_q <= '0;
    end else begin
      state_q       <= state_d;
      disp_addr_q   <= disp_addr_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      bypass_q      <= bypass_d;
      bypass_data_q <= bypass_data_d;
    end
  end

  assign bus.rd_en      = (state_q == StIssue);
  assign bus.rd_addr    = disp_addr_q;
  assign bus.disp_addr  = disp_addr_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with a registered-read RAM model.
module tb_ram_scan_reader;

  logic clock;
  logic reset;
  logic enable;
  logic ram_load;
  logic [3:0] mem [32];

  int n_checks;
  int n_errors;
  int n;

  ram_scan_reader_if #(.ADDR_W(5), .DATA_W(4)) bus ();

  ram_scan_reader #(
    .ADDR_W   (5),
    .DATA_W   (4),
    .TICK_DIV (4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: preload mem[a] = a[3:0]; one-cycle registered read.
  always @(posedge clock) begin
    if (ram_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 4'(i);
      bus.rd_data <= '0;
    end else begin
      if (bus.wr_en_snoop) mem[bus.wr_addr_snoop] <= bus.wr_data_snoop;
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until rd_en is seen; n is the number of cycles taken (20 on timeout).
  task automatic wait_rd(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!bus.rd_en && cycles < 20);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    reset             = 1'b0;
    enable            = 1'b1;
    ram_load          = 1'b1;
    bus.wr_en_snoop   = 1'b0;
    bus.wr_addr_snoop = '0;
    bus.wr_data_snoop = '0;

    repeat (3) step();
    check_eq("rst rd_en", 32'(bus.rd_en), 0);
    check_eq("rst disp_addr", 32'(bus.disp_addr), 0);
    check_eq("rst disp_data", 32'(bus.disp_data), 0);
    check_eq("rst disp_valid", 32'(bus.disp_valid), 0);
    reset    = 1'b1;
    ram_load = 1'b0;

    // First read issued the cycle after leaving IDLE, shown two cycles later.
    wait_rd(n);
    check_eq("first rd latency", 32'(n), 1);
    check_eq("first rd_addr", 32'(bus.rd_addr), 0);
    check_eq("first valid issue", 32'(bus.disp_valid), 0);
    step();
    check_eq("first valid wait", 32'(bus.disp_valid), 0);
    step();
    check_eq("first disp_data", 32'(bus.disp_data), 0);
    check_eq("first disp_valid", 32'(bus.disp_valid), 1);

    // Full wrap of the address space, continuing up to address 5.
    for (int k = 0; k < 37; k++) begin
      check_eq("scan disp_addr", 32'(bus.disp_addr), 32'(k % 32));
      check_eq("scan disp_data", 32'(bus.disp_data), 32'(k % 16));
      check_eq("scan disp_valid", 32'(bus.disp_valid), 1);
      wait_rd(n);
      check_eq("scan show cycles", 32'(n), 4);
      check_eq("scan rd_addr", 32'(bus.rd_addr), 32'((k + 1) % 32));
      check_eq("scan valid reread", 32'(bus.disp_valid), 1);
      step();
      step();
    end

    // Pause in SHOW at address 5 after one counted cycle.
    check_eq("pause addr", 32'(bus.disp_addr), 5);
    step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("pause rd_en", 32'(bus.rd_en), 0);
      check_eq("pause hold addr", 32'(bus.disp_addr), 5);
    end
    enable = 1'b1;
    wait_rd(n);
    check_eq("resume remaining", 32'(n), 3);
    check_eq("resume rd_addr", 32'(bus.rd_addr), 6);
    step();
    step();
    check_eq("resume disp_data", 32'(bus.disp_data), 6);

    // Snoop writes while showing address 7.
    wait_rd(n);
    step();
    step();
    check_eq("snoop at addr", 32'(bus.disp_addr), 7);
    check_eq("snoop before", 32'(bus.disp_data), 7);
    bus.wr_en_snoop   = 1'b1;
    bus.wr_addr_snoop = 5'd7;
    bus.wr_data_snoop = 4'hA;
    step();
    check_eq("snoop hit", 32'(bus.disp_data), 32'h A);
    bus.wr_addr_snoop = 5'd8;
    bus.wr_data_snoop = 4'h3;
    step();
    bus.wr_en_snoop = 1'b0;
    check_eq("snoop miss", 32'(bus.disp_data), 32'h A);
    check_eq("snoop miss addr", 32'(bus.disp_addr), 7);

    wait_rd(n);
    check_eq("addr8 rd_addr", 32'(bus.rd_addr), 8);
    step();
    step();
    check_eq("addr8 written data", 32'(bus.disp_data), 3);

    // Write to address 9 during its ISSUE cycle: RAM returns stale 9.
    wait_rd(n);
    check_eq("bypass rd_addr", 32'(bus.rd_addr), 9);
    bus.wr_en_snoop   = 1'b1;
    bus.wr_addr_snoop = 5'd9;
    bus.wr_data_snoop = 4'hC;
    step();
    bus.wr_en_snoop = 1'b0;
    check_eq("bypass wait data", 32'(bus.disp_data), 3);
    check_eq("bypass wait valid", 32'(bus.disp_valid), 1);
    step();
    check_eq("bypass data", 32'(bus.disp_data), 32'h C);
    check_eq("bypass addr", 32'(bus.disp_addr), 9);

    // Two matching writes at address 10: the WAIT-cycle one wins.
    wait_rd(n);
    bus.wr_en_snoop   = 1'b1;
    bus.wr_addr_snoop = 5'd10;
    bus.wr_data_snoop = 4'h1;
    step();
    bus.wr_data_snoop = 4'hE;
    step();
    bus.wr_en_snoop = 1'b0;
    check_eq("later write wins", 32'(bus.disp_data), 32'h E);

    // Reset during WAIT at address 12.
    wait_rd(n);
    wait_rd(n);
    check_eq("reset rd_addr", 32'(bus.rd_addr), 12);
    step();
    reset = 1'b0;
    #1;
    check_eq("async rst disp_addr", 32'(bus.disp_addr), 0);
    check_eq("async rst disp_data", 32'(bus.disp_data), 0);
    check_eq("async rst disp_valid", 32'(bus.disp_valid), 0);
    check_eq("async rst rd_en", 32'(bus.rd_en), 0);
    step();
    step();
    check_eq("held rst disp_data", 32'(bus.disp_data), 0);
    reset = 1'b1;
    wait_rd(n);
    check_eq("restart latency", 32'(n), 1);
    check_eq("restart rd_addr", 32'(bus.rd_addr), 0);
    step();
    check_eq("restart no partial", 32'(bus.disp_valid), 0);
    step();
    check_eq("restart disp_data", 32'(bus.disp_data), 0);
    check_eq("restart disp_valid", 32'(bus.disp_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_scan_reader.md
RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 Parameter ADDR_W, 5, RAM address width (32 words).
REQ-002 Parameter DATA_W, 4, RAM word width.
REQ-003 Parameter TICK_DIV, 50_000_000, clock cycles per scan step (1 s at 50 MHz).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-007 enable  in  1  1 = scanning advances; 0 = hold the current word.
REQ-008 rd_en  out  1  one-cycle read strobe to the RAM read port.
REQ-009 rd_addr  out  ADDR_W  RAM read address.
REQ-010 rd_data  in  DATA_W  RAM registered read data, valid the cycle after rd_en.
REQ-011 wr_en_snoop  in  1  RAM write-port enable, observed for coherence only.
REQ-012 wr_addr_snoop  in  ADDR_W  RAM write-port address, observed.
REQ-013 wr_data_snoop  in  DATA_W  RAM write-port data, observed.
REQ-014 disp_addr  out  ADDR_W  address of the displayed word.
REQ-015 disp_data  out  DATA_W  displayed word.
REQ-016 disp_valid  out  1  disp_data holds a completed read.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and SHOW.
- IDLE -> ISSUE when enable=1.
- ISSUE -> WAIT unconditionally.
- WAIT -> SHOW unconditionally.
- SHOW -> ISSUE on tick.
REQ-018 rd_en SHALL be 1 only in ISSUE; rd_addr SHALL equal disp_addr at all times.
REQ-019 At the WAIT->SHOW edge, disp_data SHALL load rd_data (or the bypass value, REQ-023) and disp_valid SHALL become 1.
- Read latency: rd_en in cycle N; disp_data and disp_valid updated from cycle N+2.
REQ-020 Tick counter SHALL count only in SHOW with enable=1.
- Clears on every entry to SHOW.
- Tick is asserted when count reaches TICK_DIV-1.
- Holds its value while enable=0.
REQ-021 On tick, disp_addr SHALL increment modulo 2^ADDR_W (31 -> 0) in the same edge as SHOW->ISSUE.
- disp_valid stays 1 during the re-read.
REQ-022 In SHOW, a snoop write with wr_addr_snoop == disp_addr SHALL update disp_data to wr_data_snoop at the next edge.
REQ-023 A matching snoop write during ISSUE or WAIT SHALL set a bypass flag and register wr_data_snoop.
- At the end of WAIT, bypass data SHALL take priority over rd_data.
- The later of two matching writes wins.
- Bypass flag clears on leaving WAIT.
REQ-024 enable=0 SHALL affect only SHOW (tick suppression) and IDLE (no exit); an in-flight ISSUE/WAIT SHALL complete.
REQ-025 Non-matching snoop writes SHALL be ignored.

Reset
REQ-026 reset=0 SHALL asynchronously force:
- state = IDLE
- disp_addr = 0, disp_data = 0, disp_valid = 0
- rd_en = 0
- tick count = 0, bypass flag = 0
REQ-027 Reset asserted mid-read SHALL abandon the read; no partial update of disp_data after reset release.

Structure
REQ-028 Package ram_scan_pkg SHALL hold ADDR_W/DATA_W defaults and the state enum type.
REQ-029 Sub-module tick_divider (parameter TICK_DIV; inputs clock, reset, clear, run; output tick) SHALL implement REQ-020.

Verification (TICK_DIV=4; RAM model preloaded with mem[a] = a[3:0])
REQ-030 Release reset with enable=1 -> rd_en pulses at addr 0 in the first cycle after IDLE; two cycles later disp_data=0, disp_valid=1.
REQ-031 Run 33 steps -> disp_addr sequence 0..31 then 0 again, disp_data=addr[3:0] each step, exactly 4 SHOW cycles between rd_en pulses.
REQ-032 Drop enable in SHOW at addr 5 for 10 cycles -> disp_addr stays 5 and no rd_en; raise enable -> resumes, advances to 6 after remaining tick count.
REQ-033 In SHOW at addr 7, snoop write addr 7 data 4'hA -> disp_data=A next cycle; snoop write addr 8 data 4'h3 -> disp_data unchanged.
REQ-034 Snoop write addr 9 data 4'hC in the ISSUE cycle for addr 9 -> disp_data=C (not the stale 9) when disp_valid updates.
REQ-035 Assert reset during WAIT at addr 12 -> all outputs 0 immediately; after release the scan restarts at addr 0.
